// File: rtl/mat_pkg.sv
// Shared definitions for the matrix coprocessor host link: opcodes,
// shared-memory map, control-unit state values and host-link FSM states.
package mat_pkg;

  localparam int WORD_W = 200;
  localparam int N_ELEM = 25;

  localparam logic [2:0] SOMA          = 3'd0;
  localparam logic [2:0] SUBTRACAO     = 3'd1;
  localparam logic [2:0] MULTIPLICACAO = 3'd2;
  localparam logic [2:0] MULT_ESCALAR  = 3'd3;
  localparam logic [2:0] DETERMINANTE  = 3'd4;
  localparam logic [2:0] TRANSPOSTA    = 3'd5;
  localparam logic [2:0] OPOSTA        = 3'd6;
  localparam logic [2:0] ILLEGAL       = 3'd7;

  localparam logic [1:0] ADDR_INSTR = 2'd0;
  localparam logic [1:0] ADDR_A     = 2'd1;
  localparam logic [1:0] ADDR_B     = 2'd2;
  localparam logic [1:0] ADDR_RES   = 2'd3;

  localparam logic [2:0] CU_IDLE = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_ARM, S_WAIT, S_READ, S_STATUS, S_SEND
  } hl_state_t;

  // Instruction word: msize in [7:0], opcode in [15:8], rest zero.
  function automatic logic [WORD_W-1:0] instr_word(input logic [2:0] op,
                                                   input logic [1:0] ms);
    return {184'b0, 5'b0, op, 6'b0, ms};
  endfunction

  function automatic logic [7:0] status_byte(input logic ill, input logic to,
                                             input logic ov);
    return {5'b0, ill, to, ov};
  endfunction

endpackage

// File: rtl/mat_byte_shifter.sv
// 200-bit byte shift register: bytes enter at the LSB end, leave from the
// MSB end, so the first byte in is the first byte out (row-major order).
module mat_byte_shifter
  import mat_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load_byte,
  input  logic [7:0]        i_din,
  input  logic              i_emit_byte,
  input  logic              i_par_load,
  input  logic [WORD_W-1:0] i_par_data,
  output logic [WORD_W-1:0] o_word
);

  logic [WORD_W-1:0] r_word;

  // Parallel load beats a byte shift; load and emit both shift left by 8.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_word <= '0;
    else if (i_par_load)  r_word <= i_par_data;
    else if (i_load_byte) r_word <= {r_word[WORD_W-9:0], i_din};
    else if (i_emit_byte) r_word <= {r_word[WORD_W-9:0], 8'h00};
  end

  assign o_word = r_word;

endmodule

// File: rtl/matrix_host_link.sv
// Host-side initiator: collects a 51-byte operation frame, writes it to the
// shared memory, runs the control unit, reads back the result and returns a
// status byte plus payload bytes to the host.
module matrix_host_link
  import mat_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mem_own,
  output logic [1:0]        mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              cu_start,
  input  logic              cu_ready,
  input  logic              cu_overflow,
  input  logic [2:0]        cu_state,
  output logic              busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(READ_LATENCY + 1);

  hl_state_t   r_state;
  logic [5:0]  r_cnt;
  logic [2:0]  r_opcode;
  logic [1:0]  r_msize;
  logic        r_illegal, r_timeout, r_overflow;
  logic [TW-1:0] r_tcnt;
  logic [RW-1:0] r_rdcnt;
  logic        r_out_valid, r_mem_own, r_mem_wren, r_cu_start;
  logic [7:0]  r_out_data;
  logic [1:0]  r_mem_addr;

  logic              w_in_fire, w_a_load, w_b_load, w_res_cap, w_res_emit;
  logic [WORD_W-1:0] w_a_word, w_b_word, w_res_word, w_res_par;
  logic [7:0]        w_res_top;
  logic              w_unused_res;

  assign in_ready  = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign busy      = (r_state != S_IDLE);
  assign w_in_fire = in_valid && in_ready;
  assign w_a_load  = (r_state == S_LOAD) && w_in_fire && (r_cnt < 6'd25);
  assign w_b_load  = (r_state == S_LOAD) && w_in_fire && (r_cnt >= 6'd25);
  assign w_res_cap = (r_state == S_READ) && (r_rdcnt == RW'(READ_LATENCY));
  // A determinant result only carries [7:0]; park it at the top so the
  // payload path always emits from [199:192].
  assign w_res_par = (r_opcode == DETERMINANTE) ? {mem_rdata[7:0], 192'b0}
                                                : mem_rdata;
  assign w_res_emit = r_out_valid && out_ready &&
                      (((r_state == S_STATUS) && !r_illegal && !r_timeout) ||
                       ((r_state == S_SEND) && (r_cnt != 6'd24)));
  assign w_res_top    = w_res_word[WORD_W-1 -: 8];
  assign w_unused_res = ^w_res_word[WORD_W-9:0];

  mat_byte_shifter u_a (.clk(clk), .rst_n(rst_n), .i_load_byte(w_a_load),
    .i_din(in_data), .i_emit_byte(1'b0), .i_par_load(1'b0),
    .i_par_data('0), .o_word(w_a_word));
  mat_byte_shifter u_b (.clk(clk), .rst_n(rst_n), .i_load_byte(w_b_load),
    .i_din(in_data), .i_emit_byte(1'b0), .i_par_load(1'b0),
    .i_par_data('0), .o_word(w_b_word));
  mat_byte_shifter u_res (.clk(clk), .rst_n(rst_n), .i_load_byte(1'b0),
    .i_din(8'h00), .i_emit_byte(w_res_emit), .i_par_load(w_res_cap),
    .i_par_data(w_res_par), .o_word(w_res_word));

  // Write data follows the write address; zero whenever not writing.
  always_comb begin
    mem_wdata = '0;
    if (r_mem_own && r_mem_wren) begin
      case (r_mem_addr)
        ADDR_INSTR: mem_wdata = instr_word(r_opcode, r_msize);
        ADDR_A:     mem_wdata = w_a_word;
        ADDR_B:     mem_wdata = w_b_word;
        default:    mem_wdata = '0;
      endcase
    end
  end

  // Main sequencer with registered memory, CU and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;      r_cnt <= '0;       r_opcode <= '0;
      r_msize <= '0;          r_illegal <= 1'b0; r_timeout <= 1'b0;
      r_overflow <= 1'b0;     r_tcnt <= '0;      r_rdcnt <= '0;
      r_out_valid <= 1'b0;    r_out_data <= '0;  r_mem_own <= 1'b0;
      r_mem_wren <= 1'b0;     r_mem_addr <= '0;  r_cu_start <= 1'b0;
    end else begin
      r_cu_start <= 1'b0;
      case (r_state)
        S_IDLE: if (in_valid) begin
          if (in_data[2:0] == ILLEGAL) begin
            r_illegal   <= 1'b1;
            r_out_valid <= 1'b1;
            r_out_data  <= status_byte(1'b1, 1'b0, 1'b0);
            r_state     <= S_STATUS;
          end else begin
            r_opcode <= in_data[2:0];
            r_msize  <= in_data[4:3];
            r_cnt    <= '0;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: if (in_valid) begin
          if (r_cnt == 6'd49) begin
            r_cnt      <= '0;
            r_mem_own  <= 1'b1;
            r_mem_wren <= 1'b1;
            r_mem_addr <= ADDR_INSTR;
            r_state    <= S_WRITE;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_WRITE: begin
          if (r_mem_addr == ADDR_B) begin
            r_mem_own  <= 1'b0;
            r_mem_wren <= 1'b0;
            r_mem_addr <= ADDR_INSTR;
            r_state    <= S_ARM;
          end else begin
            r_mem_addr <= r_mem_addr + 2'd1;
          end
        end
        S_ARM: if (cu_state == CU_IDLE) begin
          r_cu_start <= 1'b1;
          r_tcnt     <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // A done pulse in the expiry cycle still counts as success.
          if (cu_ready) begin
            r_overflow <= cu_overflow;
            r_mem_own  <= 1'b1;
            r_mem_addr <= ADDR_RES;
            r_rdcnt    <= '0;
            r_state    <= S_READ;
          end else if (r_tcnt == TW'(TIMEOUT)) begin
            r_timeout   <= 1'b1;
            r_out_valid <= 1'b1;
            r_out_data  <= status_byte(r_illegal, 1'b1, r_overflow);
            r_state     <= S_STATUS;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_READ: begin
          if (w_res_cap) begin
            r_mem_own   <= 1'b0;
            r_mem_addr  <= ADDR_INSTR;
            r_out_valid <= 1'b1;
            r_out_data  <= status_byte(r_illegal, r_timeout, r_overflow);
            r_state     <= S_STATUS;
          end else begin
            r_rdcnt <= r_rdcnt + RW'(1);
          end
        end
        S_STATUS: if (out_ready) begin
          if (r_illegal || r_timeout) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_illegal   <= 1'b0;
            r_timeout   <= 1'b0;
            r_overflow  <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_out_data <= w_res_top;
            r_cnt      <= (r_opcode == DETERMINANTE) ? 6'd24 : 6'd0;
            r_state    <= S_SEND;
          end
        end
        S_SEND: if (out_ready) begin
          if (r_cnt == 6'd24) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_illegal   <= 1'b0;
            r_timeout   <= 1'b0;
            r_overflow  <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_out_data <= w_res_top;
            r_cnt      <= r_cnt + 6'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign mem_own   = r_mem_own;
  assign mem_wren  = r_mem_wren;
  assign mem_addr  = r_mem_addr;
  assign cu_start  = r_cu_start;

endmodule

// File: tb/tb_matrix_host_link.sv
// Directed bench for matrix_host_link with a small memory and CU model.
module tb_matrix_host_link;
  localparam int RL = 2;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   in_data, out_data;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic         mem_own, mem_wren, cu_start, cu_ready, cu_overflow, busy;
  logic [1:0]   mem_addr;
  logic [199:0] mem_wdata, mem_rdata;
  logic [2:0]   cu_state;

  always #5 clk = ~clk;

  matrix_host_link #(.READ_LATENCY(RL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .mem_own(mem_own), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata),
    .cu_start(cu_start), .cu_ready(cu_ready), .cu_overflow(cu_overflow),
    .cu_state(cu_state), .busy(busy));

  int npass = 0, ntot = 0;
  int cyc = 0;
  int n_start = 0;
  int wr_addr_q[$];
  int wr_cyc_q[$];
  int cu_mode = 0;
  int last_acc = 0;

  // memory model: writes from the link, result word from the CU model
  logic [199:0] mem [0:3];
  logic [199:0] cu_res = '0;
  logic [199:0] q_pipe [0:RL-1];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_own && mem_wren) mem[mem_addr] <= mem_wdata;
    q_pipe[0] <= (mem_addr == 2'd3) ? cu_res : mem[mem_addr];
    for (int i = 1; i < RL; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign mem_rdata = q_pipe[RL-1];

  always @(negedge clk) begin
    if (cu_start === 1'b1) n_start <= n_start + 1;
    if (mem_wren === 1'b1) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_cyc_q.push_back(cyc);
    end
  end

  // CU model: mode 0 = bytewise A+B, mode 1 = determinant 0xFE with
  // overflow, mode 2 = never answers
  initial begin
    cu_ready = 1'b0; cu_overflow = 1'b0; cu_state = 3'b000;
    forever begin
      @(negedge clk);
      if (cu_start === 1'b1 && cu_mode != 2) begin
        cu_state = 3'b001;
        repeat (3) @(negedge clk);
        if (cu_mode == 1) begin
          cu_res = {8'h77, 184'h0, 8'hFE};
          cu_overflow = 1'b1;
        end else begin
          for (int k = 0; k < 25; k++)
            cu_res[8*k +: 8] = mem[1][8*k +: 8] + mem[2][8*k +: 8];
          cu_overflow = 1'b0;
        end
        cu_ready = 1'b1;
        @(negedge clk);
        cu_ready = 1'b0; cu_overflow = 1'b0; cu_state = 3'b000;
      end
    end
  end

  task automatic chk(input string tag, input logic [199:0] obs,
                     input logic [199:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    in_data = b; in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("in_ready wait", in_ready, 1);
    @(posedge clk); #1;
    last_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input int a0, input int as,
                            input int b0, input int bs);
    send_byte(hdr);
    for (int i = 0; i < 25; i++) send_byte(8'(a0 + as * i));
    for (int i = 0; i < 25; i++) send_byte(8'(b0 + bs * i));
  endtask

  task automatic recv_byte(output logic [7:0] b, input int stall);
    int t;
    t = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) chk("out_valid wait", out_valid, 1);
    b = out_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall data", out_data, b);
      chk("stall valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int w0, s0;
    in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst mem_own", mem_own, 0);
    chk("rst mem_wren", mem_wren, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst cu_start", cu_start, 0);
    chk("rst busy", busy, 0);

    // sum: A=01, B=02 -> 25 x 03
    cu_mode = 0; w0 = wr_addr_q.size(); s0 = n_start;
    send_frame(8'h18, 1, 0, 2, 0);
    recv_byte(b, 0);
    chk("sum status", b, 8'h00);
    chk("sum write count", wr_addr_q.size() - w0, 3);
    for (int i = 0; i < 3; i++) chk("sum write addr", wr_addr_q[w0+i], i);
    chk("sum writes consecutive", wr_cyc_q[w0+2] - wr_cyc_q[w0], 2);
    chk("sum first write cycle", wr_cyc_q[w0], last_acc);
    chk("sum start pulses", n_start - s0, 1);
    chk("sum mem0", mem[0], 200'h3);
    chk("sum mem1", mem[1], {25{8'h01}});
    chk("sum mem2", mem[2], {25{8'h02}});
    for (int k = 0; k < 25; k++) begin
      recv_byte(b, 0);
      chk("sum payload", b, 8'h03);
    end
    @(negedge clk);
    chk("sum end valid", out_valid, 0);
    chk("sum end busy", busy, 0);

    // determinant: status 01 then one byte FE
    cu_mode = 1;
    send_frame(8'h04, 8'h10, 1, 8'h20, 1);
    recv_byte(b, 0);
    chk("det status", b, 8'h01);
    chk("det mem0", mem[0], 200'h400);
    recv_byte(b, 0);
    chk("det payload", b, 8'hFE);
    @(negedge clk);
    chk("det end valid", out_valid, 0);
    chk("det end busy", busy, 0);

    // backpressure: A=i, B=2i -> payload 3k, stall 10 cycles mid-stream
    cu_mode = 0;
    send_frame(8'h18, 0, 1, 0, 2);
    recv_byte(b, 3);
    chk("bp status", b, 8'h00);
    for (int k = 0; k < 25; k++) begin
      recv_byte(b, (k == 7) ? 10 : 0);
      chk("bp payload", b, 8'(3 * k));
    end
    @(negedge clk);
    chk("bp end valid", out_valid, 0);

    // timeout: CU never answers
    cu_mode = 2; s0 = n_start;
    send_frame(8'h1A, 0, 0, 0, 0);
    recv_byte(b, 0);
    chk("timeout status", b, 8'h02);
    @(negedge clk);
    chk("timeout end valid", out_valid, 0);
    chk("timeout end busy", busy, 0);
    chk("timeout start pulses", n_start - s0, 1);

    // illegal opcode: no writes, no start
    cu_mode = 0; w0 = wr_addr_q.size(); s0 = n_start;
    send_byte(8'h07);
    recv_byte(b, 0);
    chk("illegal status", b, 8'h04);
    @(negedge clk);
    chk("illegal end valid", out_valid, 0);
    chk("illegal end busy", busy, 0);
    chk("illegal writes", wr_addr_q.size() - w0, 0);
    chk("illegal starts", n_start - s0, 0);

    // reset during load after 30 bytes
    send_byte(8'h18);
    for (int i = 0; i < 29; i++) send_byte(8'h55);
    @(negedge clk);
    chk("load busy", busy, 1);
    w0 = wr_addr_q.size();
    rst_n = 1'b0;
    #1;
    chk("mid rst busy", busy, 0);
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst mem_wren", mem_wren, 0);
    chk("mid rst mem_own", mem_own, 0);
    chk("mid rst cu_start", cu_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post rst in_ready", in_ready, 1);
    repeat (5) @(negedge clk);
    chk("post rst no writes", wr_addr_q.size() - w0, 0);

    send_frame(8'h18, 1, 0, 2, 0);
    recv_byte(b, 0);
    chk("after rst status", b, 8'h00);
    chk("after rst mem1", mem[1], {25{8'h01}});
    for (int k = 0; k < 25; k++) begin
      recv_byte(b, 0);
      chk("after rst payload", b, 8'h03);
    end
    @(negedge clk);
    chk("after rst end busy", busy, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
